// File: rtl/bsg_pipeline_stall_collapse_kill_pkg.sv
// Shared constants for the stall/collapse/kill pipeline controller.
package bsg_pipeline_pkg;

  localparam int perf_cnt_width_gp = 32;

  typedef enum logic [0:0] {
    e_global_stall = 1'b0,
    e_collapse     = 1'b1
  } pipe_mode_e;

endpackage

// File: rtl/bsg_pipeline_perf_counters.sv
// Saturating stall and bubble event counters for the pipeline controller.
module bsg_pipeline_perf_counters
  import bsg_pipeline_pkg::*;
#(
  parameter int width_p = perf_cnt_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               stall_i,
  input  logic               bubble_i,
  output logic [width_p-1:0] stall_cnt_o,
  output logic [width_p-1:0] bubble_cnt_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (clear_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (bubble_i && !(&bubble_cnt_o))
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_scan.sv
// Prefix scan (and/or/xor) over a vector; lo_to_hi_p=1 gives o[k] = op(i[k:0]).
module bsg_scan #(
  parameter int width_p    = 1,
  parameter int and_p      = 0,
  parameter int or_p       = 0,
  parameter int xor_p      = 0,
  parameter int lo_to_hi_p = 0
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  logic acc;
  int   idx;

  always_comb begin
    o   = '0;
    acc = 1'b0;
    idx = 0;
    for (int k = 0; k < width_p; k++) begin
      idx = (lo_to_hi_p != 0) ? k : (width_p - 1 - k);
      if (k == 0)
        acc = i[idx];
      else if (and_p != 0)
        acc = acc & i[idx];
      else if (or_p != 0)
        acc = acc | i[idx];
      else
        acc = acc ^ i[idx];
      o[idx] = acc;
    end
  end

endmodule

// File: rtl/bsg_pipeline_stall_collapse_kill.sv
// Valid/enable controller for an N-stage pipe with bubble collapse, per-stage kill and flush.
// Perf counters are built only when BSG_PIPELINE_STALL_COLLAPSE_KILL_PERF_EN is defined.
module bsg_pipeline_stall_collapse_kill
  import bsg_pipeline_pkg::*;
#(
  parameter int                  stages_p      = 3,
  parameter logic [stages_p-1:0] skip_p        = '0,
  parameter int                  collapse_p    = 1,
  parameter int                  count_width_p = $clog2(stages_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         valid_i,
  output logic                         ready_and_o,
  output logic                         valid_o,
  input  logic                         ready_and_i,
  input  logic [stages_p-1:0]          kill_i,
  input  logic                         flush_i,
  output logic [stages_p-1:0]          en_o,
  output logic [stages_p-1:0]          v_o,
  output logic [count_width_p-1:0]     count_o,
  output logic [perf_cnt_width_gp-1:0] stall_cnt_o,
  output logic [perf_cnt_width_gp-1:0] bubble_cnt_o
);

  localparam pipe_mode_e mode_lp = (collapse_p != 0) ? e_collapse : e_global_stall;

  wire  [stages_p-1:0]      v_q;
  logic [stages_p-1:0]      v_li, ve, rdy, v_n, en;
  logic                     v_in;
  logic [count_width_p-1:0] count_n, count_r;

  // Walk from the input end down so skipped stages pass their upstream valid through.
  always_comb begin
    v_in = valid_i;
    v_li = '0;
    ve   = '0;
    for (int s = stages_p - 1; s >= 0; s--) begin
      v_li[s] = v_in;
      ve[s]   = (skip_p[s] ? v_in : v_q[s]) & ~kill_i[s];
      v_in    = ve[s];
    end
  end

  if (mode_lp == e_collapse) begin : collapse
    logic [stages_p-1:0] and_prefix;
    bsg_scan #(
      .width_p   (stages_p),
      .and_p     (1),
      .lo_to_hi_p(1)
    ) prefix (
      .i(ve),
      .o(and_prefix)
    );
    assign rdy = {stages_p{ready_and_i}} | ~and_prefix;
  end else begin : gstall
    assign rdy = {stages_p{ready_and_i | ~ve[0]}};
  end

  // A killed item that is not overwritten is dropped; flush beats everything.
  always_comb begin
    v_n     = '0;
    en      = '0;
    count_n = '0;
    for (int s = 0; s < stages_p; s++) begin
      if (!skip_p[s]) begin
        if (flush_i)
          v_n[s] = 1'b0;
        else if (rdy[s])
          v_n[s] = v_li[s];
        else
          v_n[s] = v_q[s] & ~kill_i[s];
        en[s]   = v_li[s] & rdy[s] & ~flush_i & reset_n_i;
        count_n = count_n + count_width_p'(v_n[s]);
      end
    end
  end

  for (genvar s = 0; s < stages_p; s++) begin : stage
    if (skip_p[s]) begin : passthru
      assign v_q[s] = 1'b0;
    end else begin : registered
      logic q_r;
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
          q_r <= 1'b0;
        else
          q_r <= v_n[s];
      end
      assign v_q[s] = q_r;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      count_r <= '0;
    else
      count_r <= count_n;
  end

  assign count_o     = count_r;
  assign en_o        = en;
  assign v_o         = ve;
  assign valid_o     = ve[0] & ~flush_i;
  assign ready_and_o = rdy[stages_p-1] & ~flush_i;

`ifdef BSG_PIPELINE_STALL_COLLAPSE_KILL_PERF_EN
  bsg_pipeline_perf_counters #(
    .width_p(perf_cnt_width_gp)
  ) perf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (flush_i),
    .stall_i     (valid_o & ~ready_and_i),
    .bubble_i    (~valid_o & (count_r != '0)),
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
  );
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_pipeline_stall_collapse_kill.sv
// Directed bench: collapse, global-stall and skipped-stage controllers driven by shared stimulus.
module tb_bsg_pipeline_stall_collapse_kill;

  logic       clk = 1'b0;
  logic       reset_n_i, valid_i, ready_and_i, flush_i;
  logic [2:0] kill_i;

  logic        m_ready_and_o, m_valid_o;
  logic [2:0]  m_en_o, m_v_o;
  logic [1:0]  m_count_o;
  logic [31:0] m_stall_cnt_o, m_bubble_cnt_o;

  logic        g_ready_and_o, g_valid_o;
  logic [2:0]  g_en_o, g_v_o;
  logic [1:0]  g_count_o;
  logic [31:0] g_stall_cnt_o, g_bubble_cnt_o;

  logic        k_ready_and_o, k_valid_o;
  logic [2:0]  k_en_o, k_v_o;
  logic [1:0]  k_count_o;
  logic [31:0] k_stall_cnt_o, k_bubble_cnt_o;

  always #5 clk = ~clk;

  bsg_pipeline_stall_collapse_kill #(.stages_p(3), .collapse_p(1)) dut_m (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_and_o(m_ready_and_o),
    .valid_o(m_valid_o), .ready_and_i(ready_and_i), .kill_i(kill_i), .flush_i(flush_i),
    .en_o(m_en_o), .v_o(m_v_o), .count_o(m_count_o),
    .stall_cnt_o(m_stall_cnt_o), .bubble_cnt_o(m_bubble_cnt_o)
  );

  bsg_pipeline_stall_collapse_kill #(.stages_p(3), .collapse_p(0)) dut_g (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_and_o(g_ready_and_o),
    .valid_o(g_valid_o), .ready_and_i(ready_and_i), .kill_i(kill_i), .flush_i(flush_i),
    .en_o(g_en_o), .v_o(g_v_o), .count_o(g_count_o),
    .stall_cnt_o(g_stall_cnt_o), .bubble_cnt_o(g_bubble_cnt_o)
  );

  bsg_pipeline_stall_collapse_kill #(.stages_p(3), .skip_p(3'b010), .collapse_p(1)) dut_k (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_and_o(k_ready_and_o),
    .valid_o(k_valid_o), .ready_and_i(ready_and_i), .kill_i(kill_i), .flush_i(flush_i),
    .en_o(k_en_o), .v_o(k_v_o), .count_o(k_count_o),
    .stall_cnt_o(k_stall_cnt_o), .bubble_cnt_o(k_bubble_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  int unsigned exp_q[$];
  int unsigned d [3];
  int unsigned id_in;
  logic [2:0]  en_s = '0;
  logic        in_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the collapse instance: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (m_valid_o && ready_and_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed item %0d expected none", d[0]);
        end else begin
          chk("sb_item", d[0], exp_q.pop_front());
        end
      end
      if (valid_i && m_ready_and_o)
        exp_q.push_back(id_in);
    end
    en_s  = m_en_o;
    in_hs = reset_n_i & valid_i & m_ready_and_o;
  end

  // Datapath model: item ids move through registers enabled by en_o.
  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      d[0] <= 0; d[1] <= 0; d[2] <= 0;
      id_in <= 1;
    end else begin
      if (en_s[2]) d[2] <= id_in;
      if (en_s[1]) d[1] <= d[2];
      if (en_s[0]) d[0] <= d[1];
      if (in_hs) id_in <= id_in + 1;
    end
  end

  initial begin
    reset_n_i = 1'b0; valid_i = 1'b1; ready_and_i = 1'b0; kill_i = '0; flush_i = 1'b0;
    #12;
    chk("rst_valid_o", m_valid_o, 0);
    chk("rst_en_o", m_en_o, 0);
    chk("rst_v_o", m_v_o, 0);
    chk("rst_count", m_count_o, 0);
    chk("rst_ready", m_ready_and_o, 1);
    chk("rst_stall_cnt", m_stall_cnt_o, 0);
    cyc();

    // Streaming, cycle 0 is the first accepted item
    cyc(); reset_n_i = 1'b1; valid_i = 1'b1; ready_and_i = 1'b1; #1;
    chk("c0_valid_o", m_valid_o, 0);
    chk("c0_en_o", m_en_o, 3'b100);
    chk("c0_skip_valid_o", k_valid_o, 0);
    for (int c = 1; c <= 5; c++) begin
      cyc(); #1;
      chk("stream_valid_o", m_valid_o, (c >= 3));
      chk("stream_count", m_count_o, (c >= 3) ? 3 : c);
      chk("skip_valid_o", k_valid_o, (c >= 2));
      chk("skip_count", k_count_o, (c >= 2) ? 2 : c);
      chk("skip_en1", k_en_o[1], 0);
      if (c >= 2) chk("stream_en_o", m_en_o, 3'b111);
    end

    // Stall a full pipe, then kill the middle item
    cyc(); ready_and_i = 1'b0; #1;
    chk("stall_ready", m_ready_and_o, 0);
    chk("stall_en_o", m_en_o, 3'b000);
    chk("stall_count", m_count_o, 3);
    chk("stall_q_size", exp_q.size(), 3);
    cyc(); kill_i = 3'b010; valid_i = 1'b0; exp_q.delete(1); #1;
    chk("kill_ready", m_ready_and_o, 1);
    chk("kill_en_o", m_en_o, 3'b010);
    chk("kill_v_o", m_v_o, 3'b101);
    chk("kill_valid_o", m_valid_o, 1);
    cyc(); kill_i = 3'b000; valid_i = 1'b1; #1;
    chk("postkill_count", m_count_o, 2);
    chk("postkill_ready", m_ready_and_o, 1);
    chk("postkill_en_o", m_en_o, 3'b100);
    cyc(); valid_i = 1'b0; #1;
    chk("refill_count", m_count_o, 3);
    chk("refill_ready", m_ready_and_o, 0);
    ready_and_i = 1'b1;
    repeat (4) cyc();
    #1;
    chk("drain1_count", m_count_o, 0);
    chk("drain1_q_empty", exp_q.size(), 0);

    // Flush a full pipe while both handshakes would otherwise fire
    valid_i = 1'b1;
    repeat (3) cyc();
    cyc(); #1;
    chk("full_count", m_count_o, 3);
    cyc(); flush_i = 1'b1; exp_q.delete(); #1;
    chk("flush_ready", m_ready_and_o, 0);
    chk("flush_valid_o", m_valid_o, 0);
    chk("flush_en_o", m_en_o, 3'b000);
    cyc(); flush_i = 1'b0; valid_i = 1'b0; #1;
    chk("postflush_count", m_count_o, 0);
    chk("postflush_valid_o", m_valid_o, 0);
    chk("postflush_gcount", g_count_o, 0);
    chk("postflush_kcount", k_count_o, 0);

    // Build stage pattern 101 with the consumer stalled, compare both modes
    cyc(); valid_i = 1'b1; ready_and_i = 1'b0; #1;
    chk("gs_a_ready", g_ready_and_o, 1);
    cyc(); valid_i = 1'b0; #1;
    cyc(); valid_i = 1'b1; #1;
    chk("gs_c_en_o", g_en_o, 3'b101);
    chk("col_c_en_o", m_en_o, 3'b101);
    cyc(); #1;
    chk("gs_hole_v_o", g_v_o, 3'b101);
    chk("gs_hole_en_o", g_en_o, 3'b000);
    chk("gs_hole_ready", g_ready_and_o, 0);
    chk("gs_hole_count", g_count_o, 2);
    chk("col_hole_en_o", m_en_o, 3'b110);
    chk("col_hole_ready", m_ready_and_o, 1);
    cyc(); valid_i = 1'b0; #1;
    chk("gs_hold_en_o", g_en_o, 3'b000);
    chk("gs_hold_v_o", g_v_o, 3'b101);
    chk("gs_hold_ready", g_ready_and_o, 0);
    chk("col_closed_v_o", m_v_o, 3'b111);
    chk("col_closed_count", m_count_o, 3);
    ready_and_i = 1'b1;
    repeat (4) cyc();
    #1;
    chk("drain2_count", m_count_o, 0);
    chk("drain2_q_empty", exp_q.size(), 0);

    // Perf counters: flush clears, then fill and stall for five cycles
    cyc(); flush_i = 1'b1; exp_q.delete(); #1;
    cyc(); flush_i = 1'b0; valid_i = 1'b1; ready_and_i = 1'b1; #1;
    cyc(); cyc();
    cyc(); ready_and_i = 1'b0; #1;
    chk("perf_fill_valid_o", m_valid_o, 1);
    repeat (5) cyc();
    #1;
`ifdef BSG_PIPELINE_STALL_COLLAPSE_KILL_PERF_EN
    chk("perf_stall_cnt", m_stall_cnt_o, 5);
    chk("perf_bubble_cnt", m_bubble_cnt_o, 2);
`else
    chk("perf_stall_cnt_off", m_stall_cnt_o, 0);
    chk("perf_bubble_cnt_off", m_bubble_cnt_o, 0);
`endif

    // Asynchronous reset in the middle of a cycle
    reset_n_i = 1'b0; exp_q.delete(); #1;
    chk("arst_count", m_count_o, 0);
    chk("arst_valid_o", m_valid_o, 0);
    chk("arst_en_o", m_en_o, 3'b000);
    chk("arst_ready", m_ready_and_o, 1);
    chk("arst_stall_cnt", m_stall_cnt_o, 0);
    chk("arst_bubble_cnt", m_bubble_cnt_o, 0);
    cyc();
    cyc(); reset_n_i = 1'b1; valid_i = 1'b0; ready_and_i = 1'b1; #1;
    cyc(); #1;
    chk("end_valid_o", m_valid_o, 0);
    chk("end_count", m_count_o, 0);
    chk("end_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
